// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Brief    : Direct-mapped, read-only instruction cache with 4-word lines.
//             Hits return the instruction in the same cycle. A miss stalls
//             the core and refills the line from ROM with a pipelined
//             one-word-per-cycle burst. Whole-cache invalidate for fence.i.
//  Revision : 1.0  initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS     = 6,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i
);

    localparam int         c_LINES     = 1 << INDEX_BITS;
    localparam int         c_TAG_BITS  = 28 - INDEX_BITS;
    localparam logic [2:0] c_REQ_DONE  = 3'(WORDS_PER_LINE);
    localparam logic [2:0] c_LAST_WORD = 3'(WORDS_PER_LINE - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_FILL = 1'b1;

    // Storage
    logic [31:0]           r_data  [c_LINES*4];
    logic [c_TAG_BITS-1:0] r_tags  [c_LINES];
    logic [c_LINES-1:0]    r_valid;

    // Control
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [27:0] r_fill_line;   // line address pc[31:4] being refilled
    logic [2:0]  r_req_cnt;
    logic [2:0]  r_rcv_cnt;
    logic        r_discard;     // a flush hit this fill; do not validate it

    // Address split of the current fetch
    logic [INDEX_BITS-1:0] w_index;
    logic [c_TAG_BITS-1:0] w_tag;
    logic [1:0]            w_offset;
    assign w_offset = pc_i[3:2];
    assign w_index  = pc_i[INDEX_BITS+3:4];
    assign w_tag    = pc_i[31:INDEX_BITS+4];

    // Byte offset bits are never needed for word fetches
    logic w_unused_pc;
    assign w_unused_pc = &{1'b0, pc_i[1:0]};

    logic [INDEX_BITS-1:0] w_fill_index;
    logic [c_TAG_BITS-1:0] w_fill_tag;
    assign w_fill_index = r_fill_line[INDEX_BITS-1:0];
    assign w_fill_tag   = r_fill_line[27:INDEX_BITS];

    logic w_hit;
    logic w_miss;
    logic w_req_active;
    logic w_rcv_en;
    logic w_fill_done;

    assign w_hit        = ce_i & r_valid[w_index] & (r_tags[w_index] == w_tag)
                        & (r_state == c_ST_IDLE);
    assign w_miss       = ce_i & ~w_hit & (r_state == c_ST_IDLE);
    // Requests run ahead; each returned word lags its request by one cycle
    assign w_req_active = (r_state == c_ST_FILL) & (r_req_cnt != c_REQ_DONE);
    assign w_rcv_en     = (r_state == c_ST_FILL) & (r_rcv_cnt != r_req_cnt);
    assign w_fill_done  = w_rcv_en & (r_rcv_cnt == c_LAST_WORD);

    // Next state and all outputs; everything is forced to zero while in reset
    always_comb begin
        w_state_nxt = r_state;
        inst_o      = 32'd0;
        stallreq_o  = 1'b0;
        rom_ce_o    = 1'b0;
        rom_addr_o  = 32'd0;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hit) begin
                        inst_o = r_data[{w_index, w_offset}];
                    end else if (ce_i) begin
                        stallreq_o  = 1'b1;
                        w_state_nxt = c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    stallreq_o = 1'b1;
                    if (w_req_active) begin
                        rom_ce_o   = 1'b1;
                        // Offset is concatenated, so it can never carry into the tag
                        rom_addr_o = {r_fill_line, r_req_cnt[1:0], 2'b00};
                    end
                    if (w_fill_done) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // State register, fill counters, valid bits and the discard flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_fill_line <= 28'd0;
            r_req_cnt   <= 3'd0;
            r_rcv_cnt   <= 3'd0;
            r_discard   <= 1'b0;
            r_valid     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_fill_line <= pc_i[31:4];
                r_req_cnt   <= 3'd0;
                r_rcv_cnt   <= 3'd0;
            end
            if (w_req_active) begin
                r_req_cnt <= r_req_cnt + 3'd1;
            end
            if (w_rcv_en) begin
                r_rcv_cnt <= r_rcv_cnt + 3'd1;
            end
            if (flush_i) begin
                r_valid <= '0;
                if (r_state == c_ST_FILL) begin
                    r_discard <= 1'b1;
                end
            end
            // Later assignments win: a completing line overrides the flush clear
            // only if no flush touched this fill, including on this very edge
            if (w_fill_done) begin
                if (!r_discard && !flush_i) begin
                    r_valid[w_fill_index] <= 1'b1;
                end
                r_discard <= 1'b0;
            end
        end
    end

    // Refill data write, one word per returned ROM beat
    always_ff @(posedge clk) begin
        if (!rst && w_rcv_en) begin
            r_data[{w_fill_index, r_rcv_cnt[1:0]}] <= rom_data_i;
        end
    end

    // Tag write when the last word of the line lands
    always_ff @(posedge clk) begin
        if (!rst && w_fill_done) begin
            r_tags[w_fill_index] <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache
//  Brief    : Self-checking bench for icache. A ROM model answers one cycle
//             after each request; expected instructions and ROM addresses are
//             queued when a fetch is issued and compared as the DUT responds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] rom_data_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_inst_q [$];
    logic [31:0] exp_addr_q [$];

    icache #(
        .INDEX_BITS    (6),
        .WORDS_PER_LINE(4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .ce_i      (ce_i),
        .flush_i   (flush_i),
        .inst_o    (inst_o),
        .stallreq_o(stallreq_o),
        .rom_addr_o(rom_addr_o),
        .rom_ce_o  (rom_ce_o),
        .rom_data_i(rom_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content: word k holds 0x1000_0000 + k
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // ROM model: registered read, garbage when not enabled
    always @(posedge clk) begin
        if (rom_ce_o) rom_data_i <= rom_word(rom_addr_o);
        else          rom_data_i <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    endtask

    // ROM request monitor: every enabled request must match the next expected address
    always @(negedge clk) begin
        if (rom_ce_o) begin
            if (exp_addr_q.size() == 0) check("rom_ce_unexpected", {31'd0, rom_ce_o}, 32'd0);
            else                        check("rom_addr", rom_addr_o, exp_addr_q.pop_front());
        end
    end

    task automatic push_fill(input logic [31:0] pc);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk;
            kk = 2'(k);
            exp_addr_q.push_back({pc[31:4], kk, 2'b00});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles from the current cycle, then compares the returned word
    task automatic wait_ready(input int exp_stall);
        int n;
        n = 0;
        @(negedge clk);
        while (stallreq_o === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        if (exp_inst_q.size() == 0) check("inst_queue_empty", inst_o, 32'hFFFF_FFFF);
        else                        check("inst", inst_o, exp_inst_q.pop_front());
        step();
    endtask

    task automatic fetch(input logic [31:0] pc, input int exp_stall);
        pc_i = pc;
        ce_i = 1'b1;
        exp_inst_q.push_back(rom_word(pc));
        if (exp_stall > 0) push_fill(pc);
        wait_ready(exp_stall);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_inst"},  inst_o, 32'd0);
        check({tag, "_stall"}, {31'd0, stallreq_o}, 32'd0);
        check({tag, "_romce"}, {31'd0, rom_ce_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        ce_i    = 1'b1;
        pc_i    = 32'h0;
        flush_i = 1'b0;
        repeat (3) step();
        // Outputs held at zero during reset even with a fetch pending
        check_quiet("reset");
        check("reset_romaddr", rom_addr_o, 32'd0);
        step();
        rst = 1'b0;

        // First miss, then sequential hits in the same line
        fetch(32'h0000_0000, 6);
        fetch(32'h0000_0004, 0);
        fetch(32'h0000_0008, 0);
        fetch(32'h0000_000C, 0);

        // Index conflict: same index, different tag evicts the line
        fetch(32'h0000_0400, 6);
        fetch(32'h0000_0000, 6);
        fetch(32'h0000_0404, 6);

        // Redirect in cycle 2: the 0x20 fill completes, then 0x100 misses
        pc_i = 32'h0000_0020;
        ce_i = 1'b1;
        push_fill(32'h0000_0020);
        push_fill(32'h0000_0100);
        exp_inst_q.push_back(rom_word(32'h0000_0100));
        step();
        step();
        pc_i = 32'h0000_0100;
        wait_ready(10);
        fetch(32'h0000_0024, 0);

        // Flush during cycle 3 of a fill: line not validated, refilled again
        pc_i = 32'h0000_0040;
        push_fill(32'h0000_0040);
        push_fill(32'h0000_0040);
        exp_inst_q.push_back(rom_word(32'h0000_0040));
        step();
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        wait_ready(8);
        fetch(32'h0000_004C, 0);

        // Flush in IDLE: this lookup still hits, the next one misses
        fetch(32'h0000_0000, 6);
        pc_i    = 32'h0000_0008;
        flush_i = 1'b1;
        exp_inst_q.push_back(rom_word(32'h0000_0008));
        wait_ready(0);
        flush_i = 1'b0;
        fetch(32'h0000_0008, 6);

        // Top line of the address space, last index
        fetch(32'hFFFF_FFF0, 6);
        fetch(32'hFFFF_FFFC, 0);
        fetch(32'hFFFF_FFF4, 0);

        // Reset in cycle 3 of a fill abandons it
        pc_i = 32'h0000_0080;
        exp_addr_q.push_back(32'h0000_0080);
        exp_addr_q.push_back(32'h0000_0084);
        step();
        step();
        step();
        rst = 1'b1;
        check_quiet("midfill_rst_a");
        step();
        check_quiet("midfill_rst_b");
        step();
        rst = 1'b0;
        fetch(32'h0000_0080, 6);

        // Fetch disabled on a cached address
        ce_i = 1'b0;
        pc_i = 32'h0000_0084;
        check_quiet("ce_off");
        step();

        check("addr_queue_left", 32'(exp_addr_q.size()), 32'd0);
        check("inst_queue_left", 32'(exp_inst_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
